// File: rtl/mean_sched_if.sv
// Request/result handshake bundle for mean_sched: per-channel sample requests and clears
// in, tagged mean results out.
interface mean_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 8
) ();
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    clr_req;
  logic              res_valid;
  logic              res_ready;
  logic [CW-1:0]     res_ch;
  logic [DW-1:0]     res_data;
  logic              res_warm;

  modport master (
    output req_valid, req_data, clr_req, res_ready,
    input  req_ready, res_valid, res_ch, res_data, res_warm
  );

  modport slave (
    input  req_valid, req_data, clr_req, res_ready,
    output req_ready, res_valid, res_ch, res_data, res_warm
  );
endinterface

// File: rtl/mean_sched.sv
// Round-robin scheduler time-sharing one moving-average engine among NCH sample streams,
// with per-channel window warm-up tracking, clear sequencing and an engine timeout.
module mean_sched #(
  parameter int NCH      = 4,
  parameter int DW       = 8,
  parameter int WIN_LOG2 = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mean_sched_if.slave             bus,
  output logic                    eng_en,
  output logic                    eng_clr,
  output logic [$clog2(NCH)-1:0]  eng_ch,
  output logic [DW-1:0]           eng_in,
  input  logic [DW-1:0]           eng_out,
  input  logic                    eng_out_valid,
  output logic                    err_timeout
);
  localparam int CW = $clog2(NCH);
  localparam int FW = WIN_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FULL   = FW'(2 ** WIN_LOG2);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  logic [2:0]     state;
  logic [CW-1:0]  rr_ptr;
  logic [CW-1:0]  cur_ch;
  logic [DW-1:0]  cur_data;
  logic [FW-1:0]  fill [NCH];
  logic [NCH-1:0] clr_pend;
  logic [NCH-1:0] clr_pend_nxt;
  logic [TW-1:0]  wcnt;
  logic [TW-1:0]  wcnt_inc;
  logic           warm_q;
  logic           res_valid_q;
  logic [CW-1:0]  res_ch_q;
  logic [DW-1:0]  res_data_q;
  logic           res_warm_q;
  logic           err_q;

  logic [2*NCH-1:0] vv;
  logic [NCH-1:0]   rot;
  logic [CW-1:0]    off;
  logic             grant_any;
  logic [CW-1:0]    grant_ch;
  logic [CW-1:0]    clr_ch;
  logic             clr_found;

  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (CW+1)'(NCH)) s = s - (CW+1)'(NCH);
    return s[CW-1:0];
  endfunction

  // Rotate the valid vector so the search always starts at rr_ptr, then map the offset back.
  always_comb begin
    vv        = {bus.req_valid, bus.req_valid};
    rot       = NCH'(vv >> rr_ptr);
    grant_any = 1'b0;
    off       = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!grant_any && rot[i]) begin
        grant_any = 1'b1;
        off       = CW'(i);
      end
    end
    grant_ch = wrap_add(rr_ptr, off);
  end

  always_comb begin
    clr_found = 1'b0;
    clr_ch    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!clr_found && clr_pend[i]) begin
        clr_found = 1'b1;
        clr_ch    = CW'(i);
      end
    end
  end

  // A clear request arriving in the same cycle its channel is serviced stays pending.
  always_comb begin
    clr_pend_nxt = clr_pend | bus.clr_req;
    if (state == S_CLEAR)
      clr_pend_nxt = (clr_pend & ~(NCH'(1) << cur_ch)) | bus.clr_req;
  end

  assign wcnt_inc = wcnt + TW'(1);

  assign bus.req_ready = (rst_n && state == S_IDLE && clr_pend == '0 && grant_any)
                         ? (NCH'(1) << grant_ch) : '0;

  assign eng_en  = (state == S_ISSUE);
  assign eng_clr = (state == S_CLEAR);
  assign eng_ch  = (eng_en || eng_clr) ? cur_ch : '0;
  assign eng_in  = eng_en ? cur_data : '0;

  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_warm  = res_warm_q;
  assign err_timeout   = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      cur_ch      <= '0;
      cur_data    <= '0;
      clr_pend    <= '0;
      wcnt        <= '0;
      warm_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      res_warm_q  <= 1'b0;
      err_q       <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) fill[k] <= '0;
    end else begin
      clr_pend <= clr_pend_nxt;
      case (state)
        S_IDLE: begin
          if (clr_pend != '0) begin
            cur_ch <= clr_ch;
            state  <= S_CLEAR;
          end else if (grant_any) begin
            cur_ch   <= grant_ch;
            cur_data <= bus.req_data[int'(grant_ch)*DW +: DW];
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (fill[cur_ch] != FULL) fill[cur_ch] <= fill[cur_ch] + FW'(1);
          warm_q <= (fill[cur_ch] >= FULL - FW'(1));
          wcnt   <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_out_valid) begin
            res_data_q  <= eng_out;
            res_ch_q    <= cur_ch;
            res_warm_q  <= warm_q;
            res_valid_q <= 1'b1;
            state       <= S_HOLD;
          end else begin
            wcnt <= wcnt_inc;
            if (wcnt_inc == TO_LIM) begin
              err_q  <= 1'b1;
              rr_ptr <= wrap_add(cur_ch, CW'(1));
              state  <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            rr_ptr      <= wrap_add(cur_ch, CW'(1));
            state       <= S_IDLE;
          end
        end
        S_CLEAR: begin
          fill[cur_ch] <= '0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mean_sched.sv
// Bench for mean_sched: a behavioural averaging engine plus a transaction-level model of the
// scheduler (queues, round-robin arithmetic) compared against the DUT every cycle.
module tb_mean_sched;
  localparam int NCH = 4;
  localparam int DW = 8;
  localparam int WIN_LOG2 = 4;
  localparam int WIN = 16;
  localparam int TIMEOUT = 15;
  localparam int CW = $clog2(NCH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mean_sched_if #(.NCH(NCH), .DW(DW)) bus ();
  logic          eng_en, eng_clr, err_timeout;
  logic [CW-1:0] eng_ch;
  logic [DW-1:0] eng_in;
  logic [DW-1:0] eng_out = '0;
  logic          eng_out_valid = 1'b0;

  mean_sched #(.NCH(NCH), .DW(DW), .WIN_LOG2(WIN_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .eng_en(eng_en), .eng_clr(eng_clr), .eng_ch(eng_ch), .eng_in(eng_in),
    .eng_out(eng_out), .eng_out_valid(eng_out_valid), .err_timeout(err_timeout)
  );

  int n_pass = 0;
  int n_total = 0;

  // Engine: circular history per channel, answers eng_lat cycles after eng_en unless dead.
  int            eng_lat = 1;
  bit            eng_dead = 1'b0;
  logic [DW-1:0] e_hist [NCH][WIN];
  int            e_ptr [NCH];
  int            e_cnt = 0;
  logic [DW-1:0] e_pend = '0;

  always @(posedge clk) begin
    int s;
    eng_out_valid <= 1'b0;
    eng_out <= DW'($urandom);
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        e_ptr[k] <= 0;
        for (int j = 0; j < WIN; j++) e_hist[k][j] <= '0;
      end
      e_cnt <= 0;
    end else begin
      if (eng_clr) for (int j = 0; j < WIN; j++) e_hist[eng_ch][j] <= '0;
      if (eng_en) begin
        s = int'(eng_in);
        for (int j = 0; j < WIN; j++) if (j != e_ptr[eng_ch]) s += int'(e_hist[eng_ch][j]);
        e_hist[eng_ch][e_ptr[eng_ch]] <= eng_in;
        e_ptr[eng_ch] <= (e_ptr[eng_ch] + 1) % WIN;
        if (!eng_dead) begin
          if (eng_lat <= 1) begin
            eng_out_valid <= 1'b1;
            eng_out <= DW'(s >> WIN_LOG2);
          end else begin
            e_cnt <= eng_lat - 1;
            e_pend <= DW'(s >> WIN_LOG2);
          end
        end
      end else if (e_cnt > 0) begin
        if (e_cnt == 1) begin
          eng_out_valid <= 1'b1;
          eng_out <= e_pend;
        end
        e_cnt <= e_cnt - 1;
      end
    end
  end

  // Scheduler model state.
  int             m_q [NCH][$];
  int             m_fill [NCH];
  int             m_rr;
  logic [NCH-1:0] m_pend;
  bit             m_err;

  // Stimulus and observation state.
  bit             use_fixed = 1'b0;
  bit             rand_clr = 1'b0;
  logic [DW-1:0]  fixed_data [NCH];
  logic [DW-1:0]  cur_data [NCH];
  logic [NCH-1:0] extra_clr = '0;
  int cyc_n = 0, grant_cyc = 0, obs_g = -1;
  int e_rch = 0, e_rdata = 0;
  bit e_rwarm = 1'b0;
  int last_rch = 0, last_rdata = 0;
  bit last_rwarm = 1'b0, last_timeout = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic int m_mean(input int ch);
    int s = 0;
    foreach (m_q[ch][j]) s += m_q[ch][j];
    return s >> WIN_LOG2;
  endfunction

  function automatic int m_grant(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[(m_rr + i) % NCH]) return (m_rr + i) % NCH;
    return -1;
  endfunction

  function automatic int lowest(input logic [NCH-1:0] p);
    for (int i = 0; i < NCH; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_pend = '0; m_err = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      m_fill[k] = 0;
      m_q[k].delete();
    end
  endtask

  task automatic begin_cycle(input logic [NCH-1:0] v, input bit rdy);
    logic [NCH-1:0] c;
    bus.req_valid = v;
    bus.res_ready = rdy;
    for (int k = 0; k < NCH; k++) begin
      cur_data[k] = use_fixed ? fixed_data[k] : DW'($urandom);
      bus.req_data[k*DW +: DW] = cur_data[k];
    end
    c = extra_clr;
    if (rand_clr && $urandom_range(0, 19) == 0) c[$urandom_range(0, NCH-1)] = 1'b1;
    bus.clr_req = c;
    extra_clr = '0;
    #1;
  endtask

  task automatic end_cycle();
    m_pend |= bus.clr_req;
    @(negedge clk);
    cyc_n++;
  endtask

  function automatic logic [NCH-1:0] rv();
    return NCH'($urandom);
  endfunction

  task automatic chk_out(input string tag, input logic [NCH-1:0] rdy, input bit en,
                         input bit clr, input int ch, input int din, input bit rvld);
    check({tag, "/req_ready"}, longint'(bus.req_ready), longint'(rdy));
    check({tag, "/eng_en"}, longint'(eng_en), longint'(en));
    check({tag, "/eng_clr"}, longint'(eng_clr), longint'(clr));
    check({tag, "/eng_ch"}, longint'(eng_ch), longint'(ch));
    check({tag, "/eng_in"}, longint'(eng_in), longint'(din));
    check({tag, "/res_valid"}, longint'(bus.res_valid), longint'(rvld));
    check({tag, "/err_timeout"}, longint'(err_timeout), longint'(m_err));
    if (rvld) begin
      check({tag, "/res_ch"}, longint'(bus.res_ch), longint'(e_rch));
      check({tag, "/res_data"}, longint'(bus.res_data), longint'(e_rdata));
      check({tag, "/res_warm"}, longint'(bus.res_warm), longint'(e_rwarm));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    check({tag, "/req_ready"}, longint'(bus.req_ready), 0);
    check({tag, "/eng_en"}, longint'(eng_en), 0);
    check({tag, "/eng_clr"}, longint'(eng_clr), 0);
    check({tag, "/eng_ch"}, longint'(eng_ch), 0);
    check({tag, "/eng_in"}, longint'(eng_in), 0);
    check({tag, "/res_valid"}, longint'(bus.res_valid), 0);
    check({tag, "/res_ch"}, longint'(bus.res_ch), 0);
    check({tag, "/res_data"}, longint'(bus.res_data), 0);
    check({tag, "/res_warm"}, longint'(bus.res_warm), 0);
    check({tag, "/err_timeout"}, longint'(err_timeout), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0; bus.clr_req = '0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    begin_cycle('0, 1'b0);
    chk_reset_state("reset");
    end_cycle();
  endtask

  // One scheduling decision, starting in an idle cycle, walked to its end.
  task automatic run_txn(input logic [NCH-1:0] v, input int hold_n, input bit rst_in_hold,
                         input logic [NCH-1:0] wait_clr);
    int g, c, d, mean;
    bit warm, answered;
    obs_g = -1;
    last_timeout = 1'b0;
    begin_cycle(v, 1'($urandom));
    if (m_pend != '0) begin
      c = lowest(m_pend);
      chk_out("idle_clr", '0, 0, 0, 0, 0, 0);
      end_cycle();
      begin_cycle(rv(), 1'($urandom));
      chk_out("clear", '0, 0, 1, c, 0, 0);
      m_pend[c] = 1'b0;
      m_fill[c] = 0;
      m_q[c].delete();
      end_cycle();
      return;
    end
    g = m_grant(v);
    if (g < 0) begin
      chk_out("idle", '0, 0, 0, 0, 0, 0);
      end_cycle();
      return;
    end
    for (int k = 0; k < NCH; k++) if (bus.req_ready[k]) obs_g = k;
    grant_cyc = cyc_n;
    d = int'(cur_data[g]);
    chk_out("grant", NCH'(1) << g, 0, 0, 0, 0, 0);
    end_cycle();
    begin_cycle(rv(), 1'($urandom));
    chk_out("issue", '0, 1, 0, g, d, 0);
    m_q[g].push_back(d);
    if (m_q[g].size() > WIN) void'(m_q[g].pop_front());
    mean = m_mean(g);
    m_fill[g] = (m_fill[g] + 1 > WIN) ? WIN : m_fill[g] + 1;
    warm = (m_fill[g] == WIN);
    end_cycle();
    answered = 1'b0;
    for (int w = 1; w <= TIMEOUT; w++) begin
      if (w == 1) extra_clr = wait_clr;
      begin_cycle(rv(), 1'($urandom));
      chk_out("wait", '0, 0, 0, 0, 0, 0);
      answered = !eng_dead && eng_lat == w;
      end_cycle();
      if (answered) break;
    end
    if (!answered) begin
      m_err = 1'b1;
      last_timeout = 1'b1;
      m_rr = (g + 1) % NCH;
      return;
    end
    e_rch = g; e_rdata = mean; e_rwarm = warm;
    for (int h = 0; h <= hold_n; h++) begin
      begin_cycle(rv(), h == hold_n);
      chk_out("hold", '0, 0, 0, 0, 0, 1);
      if (h == 0) begin
        last_rch = int'(bus.res_ch);
        last_rdata = int'(bus.res_data);
        last_rwarm = bus.res_warm;
      end
      if (rst_in_hold) begin
        rst_n = 1'b0;
        @(negedge clk);
        cyc_n++;
        model_reset();
        rst_n = 1'b1;
        begin_cycle('0, 1'b0);
        chk_reset_state("rst_hold");
        end_cycle();
        return;
      end
      end_cycle();
    end
    m_rr = (g + 1) % NCH;
  endtask

  initial begin
    int prev, g5;
    bus.req_valid = '0; bus.req_data = '0; bus.clr_req = '0; bus.res_ready = 1'b0;

    // Single channel, constant 0x10: mean after n samples is n, warm on the 16th.
    do_reset();
    use_fixed = 1'b1;
    for (int k = 0; k < NCH; k++) fixed_data[k] = 8'h10;
    prev = 0;
    for (int i = 1; i <= 16; i++) begin
      run_txn(4'b0001, 0, 1'b0, '0);
      if (i > 1) check("t1_period", grant_cyc - prev, 4);
      prev = grant_cyc;
      check("t1_res_ch", last_rch, 0);
      if (i == 1) begin
        check("t1_first_data", last_rdata, 1);
        check("t1_first_warm", last_rwarm, 0);
      end
      if (i == 15) check("t1_15_warm", last_rwarm, 0);
      if (i == 16) begin
        check("t1_16_data", last_rdata, 16);
        check("t1_16_warm", last_rwarm, 1);
      end
    end

    // All channels valid: strict rotation 0,1,2,3,...
    do_reset();
    fixed_data[0] = 8'h01; fixed_data[1] = 8'h02; fixed_data[2] = 8'h03; fixed_data[3] = 8'h04;
    for (int i = 0; i < 8; i++) begin
      run_txn(4'b1111, 0, 1'b0, '0);
      check("t2_order", obs_g, i % NCH);
      check("t2_res_ch", last_rch, i % NCH);
    end

    // Downstream back-pressure for 10 cycles in HOLD.
    run_txn(4'b1111, 10, 1'b0, '0);

    // Clear arriving while ch2 waits on the engine.
    do_reset();
    fixed_data[2] = 8'h40;
    for (int i = 1; i <= 16; i++) run_txn(4'b0100, 0, 1'b0, '0);
    check("t4_warm_before", last_rwarm, 1);
    run_txn(4'b0100, 0, 1'b0, 4'b0100);
    check("t4_preclear_warm", last_rwarm, 1);
    check("t4_pending", m_pend, 4'b0100);
    run_txn(4'b0100, 0, 1'b0, '0);
    run_txn(4'b0100, 0, 1'b0, '0);
    check("t4_after_warm", last_rwarm, 0);
    check("t4_after_data", last_rdata, 4);

    // Dead engine: timeout, no result, next channel, sticky error.
    eng_dead = 1'b1;
    run_txn(4'b1111, 0, 1'b0, '0);
    g5 = obs_g;
    check("t5_timed_out", last_timeout, 1);
    check("t5_err", err_timeout, 1);
    eng_dead = 1'b0;
    run_txn(4'b1111, 0, 1'b0, '0);
    check("t5_next", obs_g, (g5 + 1) % NCH);
    run_txn(4'b1111, 1, 1'b0, '0);
    check("t5_sticky", err_timeout, 1);

    // Reset while holding a result; grants restart at ch0.
    run_txn(4'b1111, 2, 1'b1, '0);
    run_txn(4'b1111, 0, 1'b0, '0);
    check("t6_restart", obs_g, 0);
    check("t6_err_clear", err_timeout, 0);

    // Randomized traffic, latencies, clears and occasional dead engine or reset.
    use_fixed = 1'b0;
    rand_clr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      eng_lat = $urandom_range(1, 3);
      eng_dead = ($urandom_range(0, 39) == 0);
      run_txn(rv(), $urandom_range(0, 3), ($urandom_range(0, 99) == 0),
              ($urandom_range(0, 9) == 0) ? rv() : '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got no end, want end");
    $fatal(1);
  end
endmodule
